// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave front end: FSM encoding and the
// supported SPI mode.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    SHIFT    = 2'd2,
    WORD_END = 2'd3
  } state_t;

  localparam int         SPI_MODE       = 0;
  localparam logic [7:0] WORD_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, plus one extra stage
// that provides single-cycle rise/fall strobes on the synchronized level.
module sync_edge #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              last;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= {STAGES{INIT}};
      last  <= INIT;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      last  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~last;
  assign fall = ~q & last;

endmodule

// File: rtl/spi_slave_frontend.sv
// SPI mode-0 slave front end: synchronizes the pins, sequences an external
// shift register and collects received words with session bookkeeping.
//
// state    | meaning
// IDLE     | deselected, waiting for CS_n to fall
// LOAD     | session start: reset_flag loads first tx word, clears counters
// SHIFT    | one sel per SCK rise until the shift register reports done
// WORD_END | word captured; reset_flag reloads the next tx word
module spi_slave_frontend
  import spi_pkg::*;
#(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         spi_sck,
  input  logic         spi_cs_n,
  input  logic         spi_mosi,
  output logic         spi_miso,
  output logic         spi_miso_oe,
  output logic         sel,
  output logic         si,
  output logic         reset_flag,
  input  logic         so,
  input  logic         done_strobe,
  input  logic [N-1:0] sr_data,
  output logic [N-1:0] rx_data,
  output logic         rx_valid,
  output logic [7:0]   word_count,
  output logic         frame_error
);

  localparam int         BW         = $clog2(N + 1);
  localparam logic       SCK_IDLE   = (SPI_MODE >= 2);
  localparam logic [2:0] FLUSH_INIT = 3'(SYNC_STAGES + 1);

  logic sck_rise, sck_fall, sck_level_unused;
  logic cs_n_s, cs_rise_raw, cs_fall_raw;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .INIT(SCK_IDLE)) u_sync_sck (
    .clk(clk), .reset(reset), .d(spi_sck),
    .q(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .d(spi_cs_n),
    .q(cs_n_s), .rise(cs_rise_raw), .fall(cs_fall_raw)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d(spi_mosi),
    .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t          state, state_nxt;
  logic [2:0]      flush_cnt;
  logic            armed;
  logic            cs_rise, cs_fall;
  logic            rise_held;
  logic            reset_flag_q;
  logic [BW-1:0]   bit_cnt;
  logic            miso_q;
  logic            word_done;

  // Edges are ignored until the chains have flushed their reset levels, so a
  // CS_n held low through reset cannot masquerade as a fresh falling edge.
  assign armed   = (flush_cnt == 3'd0);
  assign cs_rise = cs_rise_raw & armed;
  assign cs_fall = cs_fall_raw & armed;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    reset_flag = 1'b0;
    sel        = 1'b0;
    word_done  = 1'b0;
    if (cs_rise) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (cs_fall) state_nxt = LOAD;
        LOAD:     state_nxt = SHIFT;
        SHIFT:    if (done_strobe) state_nxt = WORD_END;
        WORD_END: state_nxt = SHIFT;
        default:  state_nxt = IDLE;
      endcase
    end
    case (state)
      LOAD:     reset_flag = 1'b1;
      WORD_END: reset_flag = 1'b1;
      SHIFT: begin
        sel       = ~cs_n_s & (sck_rise | rise_held);
        word_done = done_strobe;
      end
      default: ;
    endcase
  end

  assign si          = mosi_s;
  assign spi_miso    = miso_q;
  assign spi_miso_oe = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      flush_cnt    <= FLUSH_INIT;
      rise_held    <= 1'b0;
      reset_flag_q <= 1'b0;
      bit_cnt      <= '0;
      miso_q       <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      word_count   <= '0;
      frame_error  <= 1'b0;
    end else begin
      if (flush_cnt != 3'd0) flush_cnt <= flush_cnt - 3'd1;

      // An SCK rise landing in a reload cycle is replayed in the next SHIFT cycle.
      rise_held    <= (state == LOAD || state == WORD_END) && sck_rise && !cs_n_s;
      reset_flag_q <= reset_flag;

      if (reset_flag)                     bit_cnt <= '0;
      else if (sel && bit_cnt != BW'(N))  bit_cnt <= bit_cnt + 1'b1;

      if (state_nxt == IDLE)              miso_q <= 1'b0;
      else if (reset_flag_q || sck_fall)  miso_q <= so;

      rx_valid <= word_done;
      if (word_done) rx_data <= sr_data;

      if (state == LOAD)
        word_count <= '0;
      else if (word_done && word_count != WORD_COUNT_MAX)
        word_count <= word_count + 8'd1;

      if (state == LOAD)
        frame_error <= 1'b0;
      else if (cs_rise && state != IDLE && bit_cnt != '0 && bit_cnt < BW'(N))
        frame_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_slave_frontend.sv
// Scoreboard bench for spi_slave_frontend with a behavioural shift register
// model; received words are queued at issue and checked on rx_valid.
module tb_spi_slave_frontend;

  localparam int N    = 8;
  localparam int HALF = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic         spi_sck, spi_cs_n, spi_mosi;
  logic         spi_miso, spi_miso_oe;
  logic         sel, si, reset_flag;
  logic         so, done_strobe;
  logic [N-1:0] sr_data;
  logic [N-1:0] rx_data;
  logic         rx_valid;
  logic [7:0]   word_count;
  logic         frame_error;

  always #5 clk = ~clk;

  spi_slave_frontend #(.N(N), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .sel(sel), .si(si), .reset_flag(reset_flag),
    .so(so), .done_strobe(done_strobe), .sr_data(sr_data),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .word_count(word_count), .frame_error(frame_error)
  );

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int sel_cnt = 0;
  int rf_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  // Behavioural MSB-first shift register that the front end sequences.
  logic [7:0] sh;
  logic [3:0] cnt;
  logic       done;
  logic [7:0] tx_pop;

  always @(posedge clk) begin
    if (reset) begin
      sh   <= 8'h00;
      cnt  <= 4'd0;
      done <= 1'b0;
    end else begin
      done <= sel && (cnt == 4'd7) && !reset_flag;
      if (reset_flag) begin
        tx_pop = 8'h00;
        if (tx_q.size() != 0) tx_pop = tx_q.pop_front();
        sh  <= tx_pop;
        cnt <= 4'd0;
      end else if (sel) begin
        sh  <= {sh[6:0], si};
        cnt <= cnt + 4'd1;
      end
    end
  end

  assign so          = sh[7];
  assign done_strobe = done;
  assign sr_data     = sh;

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got %0h expected no word", rx_data);
        end else begin
          check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
      end
      if (sel)        sel_cnt++;
      if (reset_flag) rf_cnt++;
    end
  end

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    clk_wait(8);
  endtask

  task automatic cs_high();
    spi_cs_n = 1'b1;
    clk_wait(8);
  endtask

  task automatic send_bits(input logic [7:0] mosi, input int nbits,
                           input logic [7:0] tx, input bit chk_miso);
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = mosi[i];
      clk_wait(HALF);
      if (chk_miso) check($sformatf("miso_bit%0d", i), 32'(spi_miso), 32'(tx[i]));
      spi_sck = 1'b1;
      clk_wait(HALF);
      spi_sck = 1'b0;
    end
  endtask

  task automatic send_word(input logic [7:0] mosi, input logic [7:0] tx, input bit chk_miso);
    exp_q.push_back(mosi);
    send_bits(mosi, 8, tx, chk_miso);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel"},         32'(sel),         32'd0);
    check({tag, "_si"},          32'(si),          32'd0);
    check({tag, "_reset_flag"},  32'(reset_flag),  32'd0);
    check({tag, "_miso"},        32'(spi_miso),    32'd0);
    check({tag, "_miso_oe"},     32'(spi_miso_oe), 32'd0);
    check({tag, "_rx_data"},     32'(rx_data),     32'd0);
    check({tag, "_rx_valid"},    32'(rx_valid),    32'd0);
    check({tag, "_word_count"},  32'(word_count),  32'd0);
    check({tag, "_frame_error"}, 32'(frame_error), 32'd0);
  endtask

  int rx0, rf0, sel0;

  initial begin
    reset    = 1'b1;
    spi_sck  = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    clk_wait(4);
    check_reset_outputs("reset");
    reset = 1'b0;
    clk_wait(6);

    // Single word: MOSI 0xA5, slave sends 0x3C
    rx0 = rx_cnt;
    tx_q.delete();
    tx_q.push_back(8'h3C);
    cs_low();
    check("oe_selected", 32'(spi_miso_oe), 32'd1);
    send_word(8'hA5, 8'h3C, 1'b1);
    clk_wait(8);
    check("single_rx_count", 32'(rx_cnt - rx0), 32'd1);
    check("single_word_count", 32'(word_count), 32'd1);
    check("single_frame_error", 32'(frame_error), 32'd0);
    cs_high();
    check("single_oe_after", 32'(spi_miso_oe), 32'd0);
    check("single_miso_after", 32'(spi_miso), 32'd0);

    // Two back-to-back words in one frame
    rx0 = rx_cnt;
    rf0 = rf_cnt;
    tx_q.delete();
    tx_q.push_back(8'h81);
    tx_q.push_back(8'h5A);
    cs_low();
    send_word(8'h12, 8'h81, 1'b1);
    send_word(8'hFE, 8'h5A, 1'b1);
    clk_wait(8);
    check("pair_rx_count", 32'(rx_cnt - rx0), 32'd2);
    check("pair_reset_flags", 32'(rf_cnt - rf0), 32'd3);
    check("pair_word_count", 32'(word_count), 32'd2);
    check("pair_frame_error", 32'(frame_error), 32'd0);
    cs_high();

    // Partial word: CS rises after 5 bits
    rx0 = rx_cnt;
    tx_q.delete();
    cs_low();
    send_bits(8'hC3, 5, 8'h00, 1'b0);
    clk_wait(2);
    cs_high();
    check("partial_rx_count", 32'(rx_cnt - rx0), 32'd0);
    check("partial_frame_error", 32'(frame_error), 32'd1);
    check("partial_idle_oe", 32'(spi_miso_oe), 32'd0);
    check("partial_word_count", 32'(word_count), 32'd0);
    cs_low();
    check("partial_error_cleared", 32'(frame_error), 32'd0);
    cs_high();
    check("empty_frame_error", 32'(frame_error), 32'd0);

    // SCK activity while deselected
    sel0 = sel_cnt;
    for (int i = 0; i < 10; i++) begin
      spi_mosi = i[0];
      spi_sck  = 1'b1;
      clk_wait(HALF);
      spi_sck  = 1'b0;
      clk_wait(HALF);
    end
    check("desel_sel_count", 32'(sel_cnt - sel0), 32'd0);
    check("desel_oe", 32'(spi_miso_oe), 32'd0);
    check("desel_miso", 32'(spi_miso), 32'd0);

    // Reset in the middle of a session with CS held low
    tx_q.delete();
    tx_q.push_back(8'h11);
    cs_low();
    send_bits(8'hE0, 3, 8'h00, 1'b0);
    rf0 = rf_cnt;
    rx0 = rx_cnt;
    reset = 1'b1;
    clk_wait(3);
    reset = 1'b0;
    clk_wait(1);
    check_reset_outputs("midreset");
    sel0 = sel_cnt;
    send_bits(8'hFF, 5, 8'h00, 1'b0);
    clk_wait(4);
    check("midreset_sel_count", 32'(sel_cnt - sel0), 32'd0);
    check("midreset_reset_flags", 32'(rf_cnt - rf0), 32'd0);
    check("midreset_oe", 32'(spi_miso_oe), 32'd0);
    cs_high();
    tx_q.delete();
    tx_q.push_back(8'h99);
    cs_low();
    send_word(8'h77, 8'h99, 1'b1);
    clk_wait(8);
    cs_high();
    check("midreset_rx_count", 32'(rx_cnt - rx0), 32'd1);
    check("midreset_word_count", 32'(word_count), 32'd1);

    // 300 words in one frame: counter saturates, strobes continue
    rx0 = rx_cnt;
    tx_q.delete();
    cs_low();
    for (int w = 0; w < 300; w++) send_word(8'(w * 7 + 3), 8'h00, 1'b0);
    clk_wait(8);
    check("long_rx_count", 32'(rx_cnt - rx0), 32'd300);
    check("long_word_count", 32'(word_count), 32'd255);
    check("long_frame_error", 32'(frame_error), 32'd0);
    cs_high();

    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
